lz4_input_feeder: RTL and testbench
===================================

# lz4_input_feeder

Upstream stage of the LZ4 dictionary buffer. Accepts the raw uncompressed byte stream through a valid/ready handshake and packs bytes into 32-bit words. It drives the buffer's word-write, byte-shift and byte-address inputs. It honours the buffer's busy/full flags and signals end of compression after the last byte has been written.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of buf_waddr; wraps modulo 2^ADDR_W.
- START_ADDR, 0, byte address of the first input byte after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rstN  in  1  asynchronous, active-low reset.
- in_data  in  8  input byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks the final byte of the stream; qualified by in_valid.
- in_ready  out  1  feeder accepts in_data this cycle.
- buf_unable  in  1  buffer busy (clean/stop); no writes may be issued.
- buf_full  in  1  buffer full; no writes may be issued.
- buf_idword  out  32  packed word, first byte in [31:24].
- buf_idvalid  out  1  one-cycle word-write strobe.
- buf_ishift  out  32  tail byte in [7:0]; [31:8] are zero.
- buf_isvalid  out  1  one-cycle byte-shift strobe.
- buf_waddr  out  ADDR_W  byte address of the first byte of the current write.
- compress_end  out  1  one-cycle pulse after the final write.

## Operation
- A byte is accepted when in_valid && in_ready. The accumulator holds 0–3 bytes plus a 2-bit fill count. The write pointer wr_ptr resets to START_ADDR.
- State machine:
  - IDLE: in_ready=1. The first accepted byte goes to FILL.
  - FILL: in_ready=1. On acceptance of the 4th byte, the word goes to the output register.
    - If !(buf_unable|buf_full), pulse buf_idvalid next cycle and advance wr_ptr by 4.
    - Otherwise go to HOLD.
  - HOLD: in_ready=0. The word is held. When buf_unable|buf_full drops, emit it and return to FILL, or to DRAIN/END if in_last was already captured.
  - DRAIN: entered on in_last with fill count 1–3 (counting the last byte), in_ready=0.
    - Each cycle with the stall flags low, emit one byte, oldest first, on buf_ishift[7:0] with buf_isvalid, and advance wr_ptr by 1.
    - With a stall flag high, emit nothing.
    - After the final byte, go to END.
  - END: pulse compress_end for one cycle, return to IDLE, reset wr_ptr to START_ADDR.
- in_last completing a full word: emit the word, then go to END (no DRAIN).
- buf_idvalid and buf_isvalid are never asserted in the same cycle.
- Stall flags are sampled in the issuing cycle. A strobe is never issued while buf_unable or buf_full is high.
- in_valid with in_ready=0: the byte is not taken. The upstream must hold it.
- Reset mid-operation: the accumulator, fill count and pending word are discarded. State returns to IDLE.

## Timing
- Reset values: in_ready=0 during reset and 1 in IDLE afterwards. buf_idword=0, buf_idvalid=0, buf_ishift=0, buf_isvalid=0, buf_waddr=START_ADDR, compress_end=0.
- Latency from acceptance of the 4th byte to buf_idvalid: 1 cycle when not stalled.
- buf_waddr is registered and valid in the strobe cycle.
- Throughput: 1 byte/cycle sustained. A word strobe never back-pressures FILL while not stalled.
- Drain of n tail bytes takes n unstalled cycles. compress_end follows the last strobe by exactly 1 cycle.
- wr_ptr arithmetic is ADDR_W-bit modulo. Crossing 2^ADDR_W−1 wraps to 0 with no special handling.

## Configuration
- LZ4_FEED_BSWAP_EN:
  - Defined: bytes are packed little-endian, first byte in buf_idword[7:0].
  - Undefined (default): first byte in [31:24].
  - Drain order and buf_ishift are identical in both modes.

## Structure
- Shared package lz4_pkg holds:
  - the feeder state enum (IDLE, FILL, HOLD, DRAIN, END);
  - the word-size constant LZ4_WORD_BYTES=4;
  - the default address width.
- One sub-module, lz4_feed_pack, is natural. It contains the byte accumulator, fill count and endian selection, and outputs word_ready, packed word and tail-byte selection. The top level holds the FSM, wr_ptr and output registers.

## Test plan
- 8 bytes 0x00..0x07, no stalls → idvalid at addr 0 with word 0x00010203, then addr 4 with 0x04050607; then one compress_end pulse.
- 6 bytes 0xA0..0xA5, in_last on byte 6 → word 0xA0A1A2A3 at addr 0; isvalid 0xA4 at addr 4, then 0xA5 at addr 5; compress_end 1 cycle later.
- buf_full high for 5 cycles as the 4th byte arrives → in_ready=0 and no strobe for those 5 cycles; word emitted the cycle after buf_full falls; no byte lost.
- START_ADDR=0xFFFFFFFC, 8 bytes → first word at 0xFFFFFFFC, second at 0x00000000.
- rstN asserted with 2 bytes buffered → all outputs return to reset values immediately; the following stream of 4 bytes emits one word at START_ADDR.
- LZ4_FEED_BSWAP_EN defined, bytes 0x11,0x22,0x33,0x44 → buf_idword=0x44332211.

Source files
------------

// File: rtl/lz4_pkg.sv
// rtl/lz4_pkg.sv - shared types and constants for the LZ4 input feeder
//
// Purpose: feeder state encoding, word size and default address width,
//          imported by the feeder interface, packer and top level.
// Ports:   none (package).

package lz4_pkg;

    localparam int LZ4_WORD_BYTES = 4;
    localparam int LZ4_DEF_ADDR_W = 32;

    typedef enum logic [2:0] {
        FEED_IDLE,
        FEED_FILL,
        FEED_HOLD,
        FEED_DRAIN,
        FEED_END
    } feed_state_t;

endpackage

// File: rtl/lz4_input_feeder_if.sv
// rtl/lz4_input_feeder_if.sv - byte stream and dictionary-buffer bundle for the feeder
//
// Purpose: groups the upstream byte handshake and the buffer write port.
// Ports:   in_data/in_valid/in_last/in_ready  upstream byte stream
//          buf_unable/buf_full                 buffer stall flags
//          buf_idword/buf_idvalid              word write
//          buf_ishift/buf_isvalid              tail byte shift
//          buf_waddr                           byte address of current write
//          compress_end                        end-of-stream pulse
// Modports: master = feeder side, slave = upstream/buffer side.

interface lz4_input_feeder_if
    import lz4_pkg::*;
#(
    parameter int ADDR_W = LZ4_DEF_ADDR_W
);

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              buf_unable;
    logic              buf_full;
    logic [31:0]       buf_idword;
    logic              buf_idvalid;
    logic [31:0]       buf_ishift;
    logic              buf_isvalid;
    logic [ADDR_W-1:0] buf_waddr;
    logic              compress_end;

    modport master (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready,
        input  buf_unable,
        input  buf_full,
        output buf_idword,
        output buf_idvalid,
        output buf_ishift,
        output buf_isvalid,
        output buf_waddr,
        output compress_end
    );

    modport slave (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready,
        output buf_unable,
        output buf_full,
        input  buf_idword,
        input  buf_idvalid,
        input  buf_ishift,
        input  buf_isvalid,
        input  buf_waddr,
        input  compress_end
    );

endinterface

// File: rtl/lz4_feed_pack.sv
// rtl/lz4_feed_pack.sv - byte accumulator and word packer for the LZ4 feeder
//
// Purpose: collects up to three bytes, forms the 32-bit word together with
//          the incoming fourth byte, and presents the oldest buffered byte
//          for tail draining.
// Config:  LZ4_FEED_BSWAP_EN defined -> first byte in word[7:0];
//          undefined (default)      -> first byte in word[31:24].
// Ports:   clk, rstN          clock, asynchronous active-low reset
//          accept, din        byte taken this cycle and its value
//          shift              drop the oldest buffered byte
//          word_ready         accept completes a word this cycle
//          word               packed word (valid with word_ready)
//          tail_byte          oldest buffered byte
//          fill_cnt           number of buffered bytes (0-3)

module lz4_feed_pack
    import lz4_pkg::*;
(
    input  logic        clk,
    input  logic        rstN,
    input  logic        accept,
    input  logic [7:0]  din,
    input  logic        shift,
    output logic        word_ready,
    output logic [31:0] word,
    output logic [7:0]  tail_byte,
    output logic [1:0]  fill_cnt
);

    logic [7:0] acc [0:LZ4_WORD_BYTES-2];
    logic [1:0] cnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < LZ4_WORD_BYTES - 1; i++) begin
                acc[i] <= 8'h00;
            end
            cnt <= 2'd0;
        end else if (accept) begin
            // The fourth byte bypasses the accumulator straight into the word.
            case (cnt)
                2'd0: acc[0] <= din;
                2'd1: acc[1] <= din;
                2'd2: acc[2] <= din;
                default: ;
            endcase
            cnt <= cnt + 2'd1;
        end else if (shift) begin
            // Oldest byte always sits in acc[0] during draining.
            acc[0] <= acc[1];
            acc[1] <= acc[2];
            acc[2] <= 8'h00;
            cnt    <= cnt - 2'd1;
        end
    end

    assign word_ready = accept && (cnt == 2'd3);
    assign tail_byte  = acc[0];
    assign fill_cnt   = cnt;

`ifdef LZ4_FEED_BSWAP_EN
    assign word = {din, acc[2], acc[1], acc[0]};
`else
    assign word = {acc[0], acc[1], acc[2], din};
`endif

endmodule

// File: rtl/lz4_input_feeder.sv
// rtl/lz4_input_feeder.sv - packs an input byte stream into dictionary-buffer writes
//
// Purpose: accepts bytes over a valid/ready handshake, issues 32-bit word
//          writes, drains a partial tail word byte by byte, honours the
//          buffer stall flags and pulses compress_end after the final write.
// Config:  LZ4_FEED_BSWAP_EN selects little-endian packing (see lz4_feed_pack).
// Params:  ADDR_W      byte-address width, wraps modulo 2^ADDR_W
//          START_ADDR  byte address of the first byte of each stream
// Ports:   clk         rising-edge clock
//          rstN        asynchronous active-low reset
//          bus         lz4_input_feeder_if master modport

module lz4_input_feeder
    import lz4_pkg::*;
#(
    parameter int              ADDR_W     = LZ4_DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
)(
    input  logic                 clk,
    input  logic                 rstN,
    lz4_input_feeder_if.master   bus
);

    feed_state_t       state, state_d;
    logic              last_pend, last_pend_d;
    logic              run;

    logic              stall;
    logic              accept;
    logic              in_ready;

    logic              word_ready;
    logic [31:0]       pack_word;
    logic [7:0]        tail_byte;
    logic [1:0]        fill_cnt;

    logic              load_word;
    logic              issue_word;
    logic              issue_byte;
    logic              end_now;

    logic [ADDR_W-1:0] wr_ptr;
    logic [31:0]       idword_q;
    logic              idvalid_q;
    logic [31:0]       ishift_q;
    logic              isvalid_q;
    logic [ADDR_W-1:0] waddr_q;
    logic              compress_end_q;

    assign stall  = bus.buf_unable | bus.buf_full;

    // run keeps in_ready low while reset is held and for the release edge.
    assign in_ready = run && ((state == FEED_IDLE) || (state == FEED_FILL));
    assign accept   = bus.in_valid && in_ready;

    lz4_feed_pack u_pack (
        .clk        (clk),
        .rstN       (rstN),
        .accept     (accept),
        .din        (bus.in_data),
        .shift      (issue_byte),
        .word_ready (word_ready),
        .word       (pack_word),
        .tail_byte  (tail_byte),
        .fill_cnt   (fill_cnt)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= FEED_IDLE;
            last_pend <= 1'b0;
            run       <= 1'b0;
        end else begin
            state     <= state_d;
            last_pend <= last_pend_d;
            run       <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state;
        last_pend_d = last_pend;
        load_word   = 1'b0;
        issue_word  = 1'b0;
        issue_byte  = 1'b0;
        end_now     = 1'b0;
        case (state)
            FEED_IDLE: begin
                // A fresh stream starts empty, so the first byte never completes a word.
                if (accept) begin
                    state_d = bus.in_last ? FEED_DRAIN : FEED_FILL;
                end
            end
            FEED_FILL: begin
                if (accept) begin
                    if (word_ready) begin
                        load_word = 1'b1;
                        if (stall) begin
                            state_d     = FEED_HOLD;
                            last_pend_d = bus.in_last;
                        end else begin
                            issue_word = 1'b1;
                            state_d    = bus.in_last ? FEED_END : FEED_FILL;
                        end
                    end else if (bus.in_last) begin
                        state_d = FEED_DRAIN;
                    end
                end
            end
            FEED_HOLD: begin
                // Held word always completed the accumulator, so no tail remains.
                if (!stall) begin
                    issue_word  = 1'b1;
                    last_pend_d = 1'b0;
                    state_d     = last_pend ? FEED_END : FEED_FILL;
                end
            end
            FEED_DRAIN: begin
                if (!stall) begin
                    issue_byte = 1'b1;
                    if (fill_cnt <= 2'd1) begin
                        state_d = FEED_END;
                    end
                end
            end
            FEED_END: begin
                end_now = 1'b1;
                state_d = FEED_IDLE;
            end
            default: begin
                state_d = FEED_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr         <= START_ADDR;
            idword_q       <= 32'h0;
            idvalid_q      <= 1'b0;
            ishift_q       <= 32'h0;
            isvalid_q      <= 1'b0;
            waddr_q        <= START_ADDR;
            compress_end_q <= 1'b0;
        end else begin
            idvalid_q      <= issue_word;
            isvalid_q      <= issue_byte;
            compress_end_q <= end_now;
            if (load_word) begin
                idword_q <= pack_word;
            end
            if (issue_word) begin
                waddr_q <= wr_ptr;
                wr_ptr  <= wr_ptr + ADDR_W'(LZ4_WORD_BYTES);
            end else if (issue_byte) begin
                ishift_q <= {24'h0, tail_byte};
                waddr_q  <= wr_ptr;
                wr_ptr   <= wr_ptr + ADDR_W'(1);
            end else if (end_now) begin
                wr_ptr <= START_ADDR;
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.buf_idword   = idword_q;
    assign bus.buf_idvalid  = idvalid_q;
    assign bus.buf_ishift   = ishift_q;
    assign bus.buf_isvalid  = isvalid_q;
    assign bus.buf_waddr    = waddr_q;
    assign bus.compress_end = compress_end_q;

endmodule

// File: tb/tb_lz4_input_feeder.sv
// tb/tb_lz4_input_feeder.sv - directed self-checking bench for lz4_input_feeder

module tb_lz4_input_feeder;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       buf_unable = 1'b0;
    logic       buf_full = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int excl_viol = 0;
    int stall_viol = 0;
    logic stall_at_edge = 1'b0;

    logic [31:0] w_data[$];
    logic [31:0] w_addr[$];
    int          w_cyc[$];
    logic [31:0] w1_addr[$];
    logic [31:0] b_data[$];
    logic [31:0] b_addr[$];
    int          b_cyc[$];
    int          e_cyc[$];

    always #5 clk = ~clk;

    lz4_input_feeder_if #(.ADDR_W(32)) u_if0 ();
    lz4_input_feeder_if #(.ADDR_W(32)) u_if1 ();

    assign u_if0.in_data    = in_data;
    assign u_if0.in_valid   = in_valid;
    assign u_if0.in_last    = in_last;
    assign u_if0.buf_unable = buf_unable;
    assign u_if0.buf_full   = buf_full;
    assign u_if1.in_data    = in_data;
    assign u_if1.in_valid   = in_valid;
    assign u_if1.in_last    = in_last;
    assign u_if1.buf_unable = buf_unable;
    assign u_if1.buf_full   = buf_full;

    lz4_input_feeder #(.ADDR_W(32), .START_ADDR(32'h0000_0000)) u_dut0 (
        .clk  (clk),
        .rstN (rstN),
        .bus  (u_if0.master)
    );

    lz4_input_feeder #(.ADDR_W(32), .START_ADDR(32'hFFFF_FFFC)) u_dut1 (
        .clk  (clk),
        .rstN (rstN),
        .bus  (u_if1.master)
    );

    always @(posedge clk) begin
        cyc           <= cyc + 1;
        stall_at_edge <= buf_unable | buf_full;
    end

    always @(negedge clk) begin
        if (u_if0.buf_idvalid) begin
            w_data.push_back(u_if0.buf_idword);
            w_addr.push_back(u_if0.buf_waddr);
            w_cyc.push_back(cyc);
        end
        if (u_if1.buf_idvalid) begin
            w1_addr.push_back(u_if1.buf_waddr);
        end
        if (u_if0.buf_isvalid) begin
            b_data.push_back(u_if0.buf_ishift);
            b_addr.push_back(u_if0.buf_waddr);
            b_cyc.push_back(cyc);
        end
        if (u_if0.compress_end) begin
            e_cyc.push_back(cyc);
        end
        if (u_if0.buf_idvalid && u_if0.buf_isvalid) begin
            excl_viol <= excl_viol + 1;
        end
        if ((u_if0.buf_idvalid || u_if0.buf_isvalid) && stall_at_edge) begin
            stall_viol <= stall_viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
`ifdef LZ4_FEED_BSWAP_EN
        return {d, c, b, a};
`else
        return {a, b, c, d};
`endif
    endfunction

    task automatic clear_q();
        w_data.delete(); w_addr.delete(); w_cyc.delete(); w1_addr.delete();
        b_data.delete(); b_addr.delete(); b_cyc.delete(); e_cyc.delete();
    endtask

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        while (!u_if0.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'(n), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values while reset is held.
        idle(3);
        chk("rst_in_ready", u_if0.in_ready, 1'b0);
        chk("rst_idword", u_if0.buf_idword, 32'h0);
        chk("rst_idvalid", u_if0.buf_idvalid, 1'b0);
        chk("rst_ishift", u_if0.buf_ishift, 32'h0);
        chk("rst_isvalid", u_if0.buf_isvalid, 1'b0);
        chk("rst_waddr0", u_if0.buf_waddr, 32'h0);
        chk("rst_waddr1", u_if1.buf_waddr, 32'hFFFF_FFFC);
        chk("rst_cend", u_if0.compress_end, 1'b0);
        rstN = 1'b1;
        idle(2);
        chk("idle_in_ready", u_if0.in_ready, 1'b1);

        // Two full words, no stalls; second DUT wraps its address.
        clear_q();
        for (int i = 0; i < 8; i++) send(8'(i), i == 7);
        idle(6);
        chk("t1_nwords", w_data.size(), 2);
        chk("t1_word0", w_data[0], 32'h0001_0203 ^ (pk(8'h00,8'h01,8'h02,8'h03) ^ 32'h0001_0203));
        chk("t1_word0_hand", w_data[0], pk(8'h00, 8'h01, 8'h02, 8'h03));
        chk("t1_addr0", w_addr[0], 32'h0);
        chk("t1_word1", w_data[1], pk(8'h04, 8'h05, 8'h06, 8'h07));
        chk("t1_addr1", w_addr[1], 32'h4);
        chk("t1_gap", 64'(w_cyc[1] - w_cyc[0]), 64'd4);
        chk("t1_wrap_addr0", w1_addr[0], 32'hFFFF_FFFC);
        chk("t1_wrap_addr1", w1_addr[1], 32'h0000_0000);
        chk("t1_nend", e_cyc.size(), 1);
        chk("t1_end_lat", 64'(e_cyc[0] - w_cyc[1]), 64'd1);
        chk("t1_nbytes", b_data.size(), 0);

        // Six bytes: one word plus a two-byte drain.
        clear_q();
        for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), i == 5);
        idle(8);
        chk("t2_nwords", w_data.size(), 1);
        chk("t2_word0", w_data[0], pk(8'hA0, 8'hA1, 8'hA2, 8'hA3));
        chk("t2_addr0", w_addr[0], 32'h0);
        chk("t2_nbytes", b_data.size(), 2);
        chk("t2_byte0", b_data[0], 32'h0000_00A4);
        chk("t2_baddr0", b_addr[0], 32'h4);
        chk("t2_byte1", b_data[1], 32'h0000_00A5);
        chk("t2_baddr1", b_addr[1], 32'h5);
        chk("t2_bgap", 64'(b_cyc[1] - b_cyc[0]), 64'd1);
        chk("t2_nend", e_cyc.size(), 1);
        chk("t2_end_lat", 64'(e_cyc[0] - b_cyc[1]), 64'd1);

        // buf_full high for 5 cycles as the 4th byte is taken.
        clear_q();
        for (int i = 0; i < 3; i++) send(8'hB0 + 8'(i), 1'b0);
        buf_full = 1'b1;
        send(8'hB3, 1'b0);
        in_data  = 8'hB4;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_ready", u_if0.in_ready, 1'b0);
            chk("t3_hold_idvalid", u_if0.buf_idvalid, 1'b0);
            @(negedge clk);
        end
        buf_full = 1'b0;
        chk("t3_drop_idvalid", u_if0.buf_idvalid, 1'b0);
        @(negedge clk);
        chk("t3_emit_idvalid", u_if0.buf_idvalid, 1'b1);
        chk("t3_emit_word", u_if0.buf_idword, pk(8'hB0, 8'hB1, 8'hB2, 8'hB3));
        chk("t3_emit_addr", u_if0.buf_waddr, 32'h0);
        for (int i = 4; i < 8; i++) send(8'hB0 + 8'(i), i == 7);
        idle(6);
        chk("t3_nwords", w_data.size(), 2);
        chk("t3_word1", w_data[1], pk(8'hB4, 8'hB5, 8'hB6, 8'hB7));
        chk("t3_addr1", w_addr[1], 32'h4);
        chk("t3_nend", e_cyc.size(), 1);

        // buf_unable blocks the tail drain.
        clear_q();
        for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i), 1'b0);
        buf_unable = 1'b1;
        send(8'hE4, 1'b1);
        idle(3);
        chk("t4_stall_nbytes", b_data.size(), 0);
        chk("t4_stall_nwords", w_data.size(), 1);
        buf_unable = 1'b0;
        idle(5);
        chk("t4_nbytes", b_data.size(), 1);
        chk("t4_byte0", b_data[0], 32'h0000_00E4);
        chk("t4_baddr0", b_addr[0], 32'h4);
        chk("t4_nend", e_cyc.size(), 1);
        chk("t4_end_lat", 64'(e_cyc[0] - b_cyc[0]), 64'd1);

        // Reset with two bytes buffered.
        clear_q();
        send(8'hC0, 1'b0);
        send(8'hC1, 1'b0);
        rstN = 1'b0;
        #1;
        chk("t5_rst_ready", u_if0.in_ready, 1'b0);
        chk("t5_rst_idword", u_if0.buf_idword, 32'h0);
        chk("t5_rst_waddr0", u_if0.buf_waddr, 32'h0);
        chk("t5_rst_waddr1", u_if1.buf_waddr, 32'hFFFF_FFFC);
        chk("t5_rst_ishift", u_if0.buf_ishift, 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        idle(2);
        clear_q();
        for (int i = 0; i < 4; i++) send(8'hD0 + 8'(i), i == 3);
        idle(5);
        chk("t5_nwords", w_data.size(), 1);
        chk("t5_word0", w_data[0], pk(8'hD0, 8'hD1, 8'hD2, 8'hD3));
        chk("t5_addr0", w_addr[0], 32'h0);
        chk("t5_addr0_dut1", w1_addr[0], 32'hFFFF_FFFC);
        chk("t5_nend", e_cyc.size(), 1);

        // Endianness of the packed word.
        clear_q();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        idle(4);
`ifdef LZ4_FEED_BSWAP_EN
        chk("t6_endian", w_data[0], 32'h4433_2211);
`else
        chk("t6_endian", w_data[0], 32'h1122_3344);
`endif

        chk("excl_strobes", 64'(excl_viol), 64'd0);
        chk("strobe_under_stall", 64'(stall_viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
